mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
// Control FSM that sequences the shared-memory multicycle MIPS datapath: one instruction
// per 3-5 cycles. One memory port serves both instruction fetch and data access.
// Reads op/funct/zero from the datapath; drives every mux select, write enable and ALU op.
// Sits inside the mips core beside the datapath; top-level memory hookup is unchanged.
// PARAMETERS
// HALT_ON_ILLEGAL  0  1: an unknown opcode parks the FSM in HALT until reset; 0: treat as NOP
// PORTS
// clk         in   1  system clock, all state on rising edge
// reset       in   1  synchronous, active-high
// op          in   6  instr[31:26] from instruction register
// funct       in   6  instr[5:0] from instruction register
// zero        in   1  ALU zero flag, same cycle
// iord        out  1  memory address select: 0=PC, 1=ALUOut
// memwrite    out  1  data memory write enable
// irwrite     out  1  instruction register load
// regdst      out  1  write register select: 0=rt, 1=rd
// memtoreg    out  1  writeback data select: 0=ALUOut, 1=MDR
// regwrite    out  1  register file write enable
// alusrca     out  1  ALU A select: 0=PC, 1=A reg
// alusrcb     out  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
// pcsrc       out  2  next-PC select: 00=ALUResult, 01=ALUOut, 10=jump target
// pcen        out  1  PC load = pcwrite | (branch&zero) | (branchne&~zero)
// alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
// halted      out  1  high while in HALT
// state_o     out  4  current state encoding, for debug and bench
// BEHAVIOUR
// - Moore FSM. Outputs decode from state only; pcen also depends on zero.
//   Unlisted outputs are 0.
// - While reset=1: next state FETCH; pcen, irwrite, regwrite and memwrite are forced 0.
//   First post-reset cycle is FETCH. Reset mid-instruction aborts it at the next edge.
// - FETCH:   iord=0, alusrcb=01, irwrite=1, pcwrite=1 (PC+4)            -> DECODE
// - DECODE:  alusrcb=11 (branch target into ALUOut)
//   lw/sw -> MEMADR; R(000000) -> RTYPEEX; beq(000100)/bne(000101) -> BEQEX;
//   addi(001000) -> ADDIEX; j(000010) -> JEX;
//   other -> HALT if HALT_ON_ILLEGAL, else FETCH.
// - MEMADR:  alusrca=1, alusrcb=10                   -> lw(100011) MEMRD; sw(101011) MEMWR
// - MEMRD:   iord=1                                  -> MEMWB
// - MEMWB:   memtoreg=1, regwrite=1                  -> FETCH
// - MEMWR:   iord=1, memwrite=1                      -> FETCH
// - RTYPEEX: alusrca=1, aluop=10                     -> RTYPEWB
// - RTYPEWB: regdst=1, regwrite=1                    -> FETCH
// - BEQEX:   alusrca=1, aluop=01, pcsrc=01; branch=1 for beq, branchne=1 for bne -> FETCH
// - ADDIEX:  alusrca=1, alusrcb=10                   -> ADDIWB
// - ADDIWB:  regwrite=1                              -> FETCH
// - JEX:     pcsrc=10, pcwrite=1                     -> FETCH
// - HALT:    all enables 0, halted=1, self-loop; exits only through reset.
// - Latency in cycles: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3.
// - bne uses the op latched in DECODE via the IR; op is stable from FETCH+1 until next FETCH.
// - ALU decode: aluop 00 -> add, 01 -> sub, 10 -> funct:
//   100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other -> add (010).
// - Illegal state encodings recover to FETCH on the next edge.
// STRUCTURE
// - Package mips_ctrl_pkg: state_t enum (4-bit), opcode and funct localparams, aluop_t.
// - Sub-module mips_aludec (combinational: aluop, funct -> alucontrol).
// - Main body: state register, next-state case, output case.
// TESTING
// - Reset held 3 cycles, then lw: state FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH;
//   regwrite=1 and memtoreg=1 only in MEMWB.
// - sw: memwrite=1, iord=1 in exactly one cycle (cycle 4); regwrite never 1.
// - beq, zero=1: pcen=1 with pcsrc=01 in cycle 3. zero=0: pcen=0 in cycle 3.
//   bne gives the inverse result.
// - R-type funct 101010: alucontrol=111 in RTYPEEX; regdst=1 and regwrite=1 in RTYPEWB.
//   funct 000000: alucontrol=010.
// - op 111111, HALT_ON_ILLEGAL=1: HALT after DECODE, halted=1, all enables 0 for 20 cycles.
//   HALT_ON_ILLEGAL=0: back to FETCH after 2 cycles.
// - Reset asserted in MEMRD: next state FETCH; regwrite/memwrite never pulse; pcen=0 while reset=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
//   state_t : 4-bit FSM state encoding, visible on state_o
//   aluop_t : main-FSM to ALU-decoder operation class
//   Op*     : opcode field values (instr[31:26])
//   Funct*  : R-type funct field values (instr[5:0])
//   Alu*    : alucontrol encodings driven to the datapath ALU
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11,
    StHalt    = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } aluop_t;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// Combinational ALU decoder.
//   aluop      in  2  operation class from the main FSM (add / sub / use funct)
//   funct      in  6  R-type funct field
//   alucontrol out 3  ALU operation select
module mips_aludec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = AluAdd;
    case (aluop)
      AluOpAdd: alucontrol = AluAdd;
      AluOpSub: alucontrol = AluSub;
      AluOpFunct: begin
        case (funct)
          FunctAdd: alucontrol = AluAdd;
          FunctSub: alucontrol = AluSub;
          FunctAnd: alucontrol = AluAnd;
          FunctOr:  alucontrol = AluOr;
          FunctSlt: alucontrol = AluSlt;
          default:  alucontrol = AluAdd;
        endcase
      end
      default: alucontrol = AluAdd;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Control FSM for the shared-memory multicycle MIPS datapath.
// Moore machine: every output is decoded from the current state, except pcen which also
// folds in the ALU zero flag for conditional branches.
//   clk, reset (sync, active-high)
//   op, funct, zero                       : from IR / ALU
//   iord, memwrite, irwrite, regdst,
//   memtoreg, regwrite, alusrca, alusrcb,
//   pcsrc, pcen, alucontrol               : datapath controls
//   halted                                : FSM parked after an illegal opcode
//   state_o                               : current state encoding
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       halted,
  output logic [3:0] state_o
);

  state_t state_q, state_d;

  logic       pcwrite, branch, branchne;
  logic       memwrite_s, irwrite_s, regwrite_s;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = StFetch;
    if (!reset) begin
      case (state_q)
        StFetch: state_d = StDecode;
        StDecode: begin
          case (op)
            OpLw, OpSw:    state_d = StMemAdr;
            OpRtype:       state_d = StRtypeEx;
            OpBeq, OpBne:  state_d = StBeqEx;
            OpAddi:        state_d = StAddiEx;
            OpJ:           state_d = StJEx;
            default:       state_d = HALT_ON_ILLEGAL ? StHalt : StFetch;
          endcase
        end
        StMemAdr:  state_d = (op == OpSw) ? StMemWr : StMemRd;
        StMemRd:   state_d = StMemWb;
        StMemWb:   state_d = StFetch;
        StMemWr:   state_d = StFetch;
        StRtypeEx: state_d = StRtypeWb;
        StRtypeWb: state_d = StFetch;
        StBeqEx:   state_d = StFetch;
        StAddiEx:  state_d = StAddiWb;
        StAddiWb:  state_d = StFetch;
        StJEx:     state_d = StFetch;
        StHalt:    state_d = StHalt;
        default:   state_d = StFetch;  // unused encodings recover
      endcase
    end
  end

  // Output decode; enables are collected here and gated by reset below.
  always_comb begin
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    aluop      = AluOpAdd;
    halted     = 1'b0;
    case (state_q)
      StFetch: begin
        alusrcb   = 2'b01;
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
      end
      StDecode: alusrcb = 2'b11;
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: iord = 1'b1;
      StMemWb: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      StMemWr: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      StRtypeEx: begin
        alusrca = 1'b1;
        aluop   = AluOpFunct;
      end
      StRtypeWb: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      StBeqEx: begin
        alusrca  = 1'b1;
        aluop    = AluOpSub;
        pcsrc    = 2'b01;
        // op still holds the IR opcode latched in fetch
        branch   = (op == OpBeq);
        branchne = (op == OpBne);
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StAddiWb: regwrite_s = 1'b1;
      StJEx: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      StHalt: halted = 1'b1;
      default: ;
    endcase
  end

  // Architectural state must not change in the cycle reset is sampled.
  assign pcen     = ~reset & (pcwrite | (branch & zero) | (branchne & ~zero));
  assign irwrite  = ~reset & irwrite_s;
  assign regwrite = ~reset & regwrite_s;
  assign memwrite = ~reset & memwrite_s;
  assign state_o  = state_q;

  mips_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl. Main instance halts on illegal opcodes; a second
// instance sharing the same inputs treats them as NOP.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;

  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, halted;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;

  logic       iord0, memwrite0, irwrite0, regdst0, memtoreg0, regwrite0, alusrca0, pcen0;
  logic       halted0;
  logic [1:0] alusrcb0, pcsrc0;
  logic [2:0] alucontrol0;
  logic [3:0] state0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .halted(halted),
    .state_o(state_o)
  );

  mips_multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord0), .memwrite(memwrite0), .irwrite(irwrite0), .regdst(regdst0),
    .memtoreg(memtoreg0), .regwrite(regwrite0), .alusrca(alusrca0), .alusrcb(alusrcb0),
    .pcsrc(pcsrc0), .pcen(pcen0), .alucontrol(alucontrol0), .halted(halted0),
    .state_o(state0)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs are changed 2 time units after the edge, outputs sampled then.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;

    // Reset held 3 cycles; FETCH enables suppressed while reset is high.
    tick();
    check("rst_state", 8'(state_o), 8'(StFetch));
    check("rst_pcen", 8'(pcen), 8'd0);
    check("rst_irwrite", 8'(irwrite), 8'd0);
    tick();
    tick();

    // lw: 5 cycles
    reset = 1'b0; op = 6'b100011; #1;
    check("lw_c1_state", 8'(state_o), 8'(StFetch));
    check("lw_c1_ctrl", {iord, irwrite, pcen, alusrcb, 3'b0}, {1'b0, 1'b1, 1'b1, 2'b01, 3'b0});
    tick();
    check("lw_c2_state", 8'(state_o), 8'(StDecode));
    check("lw_c2_ctrl", {pcen, irwrite, alusrcb, 4'b0}, {1'b0, 1'b0, 2'b11, 4'b0});
    tick();
    check("lw_c3_state", 8'(state_o), 8'(StMemAdr));
    check("lw_c3_ctrl", {alusrca, alusrcb, alucontrol, 2'b0}, {1'b1, 2'b10, 3'b010, 2'b0});
    tick();
    check("lw_c4_state", 8'(state_o), 8'(StMemRd));
    check("lw_c4_ctrl", {iord, regwrite, memtoreg, 5'b0}, {1'b1, 1'b0, 1'b0, 5'b0});
    tick();
    check("lw_c5_state", 8'(state_o), 8'(StMemWb));
    check("lw_c5_ctrl", {regwrite, memtoreg, iord, 5'b0}, {1'b1, 1'b1, 1'b0, 5'b0});
    tick();
    check("lw_done_state", 8'(state_o), 8'(StFetch));
    check("lw_done_regwrite", 8'(regwrite), 8'd0);

    // sw: 4 cycles, single memwrite pulse
    op = 6'b101011;
    tick();
    check("sw_c2_memwrite", 8'(memwrite), 8'd0);
    tick();
    check("sw_c3_state", 8'(state_o), 8'(StMemAdr));
    check("sw_c3_memwrite", 8'(memwrite), 8'd0);
    tick();
    check("sw_c4_state", 8'(state_o), 8'(StMemWr));
    check("sw_c4_ctrl", {memwrite, iord, regwrite, 5'b0}, {1'b1, 1'b1, 1'b0, 5'b0});
    tick();
    check("sw_done_state", 8'(state_o), 8'(StFetch));
    check("sw_done_memwrite", 8'(memwrite), 8'd0);

    // beq: 3 cycles, pcen follows zero
    op = 6'b000100; zero = 1'b1;
    tick();
    tick();
    check("beq_state", 8'(state_o), 8'(StBeqEx));
    check("beq_z1", {pcen, pcsrc, alucontrol, alusrca, 1'b0}, {1'b1, 2'b01, 3'b110, 1'b1, 1'b0});
    zero = 1'b0; #1;
    check("beq_z0_pcen", 8'(pcen), 8'd0);
    tick();
    check("beq_done_state", 8'(state_o), 8'(StFetch));

    // bne: inverse sense
    op = 6'b000101; zero = 1'b1;
    tick();
    tick();
    check("bne_state", 8'(state_o), 8'(StBeqEx));
    check("bne_z1_pcen", 8'(pcen), 8'd0);
    zero = 1'b0; #1;
    check("bne_z0", {pcen, pcsrc, 5'b0}, {1'b1, 2'b01, 5'b0});
    tick();
    check("bne_done_state", 8'(state_o), 8'(StFetch));

    // R-type: ALU decode in RTYPEEX, writeback to rd
    op = 6'b000000; funct = 6'b101010;
    tick();
    tick();
    check("r_ex_state", 8'(state_o), 8'(StRtypeEx));
    check("r_slt", 8'(alucontrol), 8'b111);
    funct = 6'b000000; #1;
    check("r_unknown_add", 8'(alucontrol), 8'b010);
    funct = 6'b100010; #1;
    check("r_sub", 8'(alucontrol), 8'b110);
    funct = 6'b100100; #1;
    check("r_and", 8'(alucontrol), 8'b000);
    funct = 6'b100101; #1;
    check("r_or", 8'(alucontrol), 8'b001);
    tick();
    check("r_wb_state", 8'(state_o), 8'(StRtypeWb));
    check("r_wb_ctrl", {regdst, regwrite, memtoreg, 5'b0}, {1'b1, 1'b1, 1'b0, 5'b0});
    tick();
    check("r_done_state", 8'(state_o), 8'(StFetch));

    // addi: 4 cycles
    op = 6'b001000;
    tick();
    tick();
    check("addi_ex_state", 8'(state_o), 8'(StAddiEx));
    check("addi_ex_ctrl", {alusrca, alusrcb, alucontrol, 2'b0}, {1'b1, 2'b10, 3'b010, 2'b0});
    tick();
    check("addi_wb_state", 8'(state_o), 8'(StAddiWb));
    check("addi_wb_ctrl", {regwrite, regdst, memtoreg, 5'b0}, {1'b1, 1'b0, 1'b0, 5'b0});
    tick();
    check("addi_done_state", 8'(state_o), 8'(StFetch));

    // j: 3 cycles
    op = 6'b000010;
    tick();
    tick();
    check("j_state", 8'(state_o), 8'(StJEx));
    check("j_ctrl", {pcen, pcsrc, 5'b0}, {1'b1, 2'b10, 5'b0});
    tick();
    check("j_done_state", 8'(state_o), 8'(StFetch));

    // Illegal opcode: main instance parks in HALT, NOP instance returns to FETCH
    op = 6'b111111;
    tick();
    check("ill_decode_state", 8'(state_o), 8'(StDecode));
    tick();
    check("ill_nop_state", 8'(state0), 8'(StFetch));
    for (int i = 0; i < 20; i++) begin
      check("halt_state", 8'(state_o), 8'(StHalt));
      check("halt_flags", {halted, pcen, irwrite, regwrite, memwrite, 3'b0}, 8'b1000_0000);
      tick();
    end

    // Reset aborts a load in MEMRD
    reset = 1'b1;
    tick();
    check("halt_rst_state", 8'(state_o), 8'(StFetch));
    check("halt_rst_halted", 8'(halted), 8'd0);
    reset = 1'b0; op = 6'b100011;
    tick();
    tick();
    tick();
    check("abort_memrd_state", 8'(state_o), 8'(StMemRd));
    reset = 1'b1; #1;
    check("abort_in_reset", {pcen, regwrite, memwrite, 5'b0}, 8'd0);
    tick();
    check("abort_state", 8'(state_o), 8'(StFetch));
    check("abort_enables", {pcen, irwrite, regwrite, memwrite, 4'b0}, 8'd0);
    reset = 1'b0; #1;
    check("abort_release", {irwrite, pcen, regwrite, 5'b0}, {1'b1, 1'b1, 1'b0, 5'b0});
    tick();
    check("abort_next_state", 8'(state_o), 8'(StDecode));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
